ctrl_decode_pipe: RTL and testbench

// Registered instruction decoder with a valid/ready handshake and saturating performance counters.

---
 rtl/ctrl_decode_pipe_if.sv | 22 ++
 rtl/ctrl_decode_pipe.sv | 255 +++++++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_decode_pipe_if.sv
// Handshake bundle between fetch/ID, the control decoder and the issue stage.
// master drives instructions in and consumes control words; slave is the decoder.
interface ctrl_decode_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  instr_type;
  logic [4:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] ctrl_word;
  logic        illegal;

  modport master (
    output in_valid, instr_type, opcode, out_ready,
    input  in_ready, out_valid, ctrl_word, illegal
  );

  modport slave (
    input  in_valid, instr_type, opcode, out_ready,
    output in_ready, out_valid, ctrl_word, illegal
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Registered instruction decoder: one-deep valid/ready output stage plus
// saturating (or wrapping) performance counters with clear and snapshot.
module ctrl_decode_pipe #(
  parameter int unsigned CNT_W    = 19,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_decode_pipe_if.slave bus,
  input  logic             cnt_clr,
  input  logic             snap,
  output logic [CNT_W-1:0] cnt_instr,
  output logic [CNT_W-1:0] cnt_arith,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_illegal,
  output logic [CNT_W-1:0] snp_instr,
  output logic [CNT_W-1:0] snp_arith,
  output logic [CNT_W-1:0] snp_mem,
  output logic [CNT_W-1:0] snp_stall,
  output logic [CNT_W-1:0] snp_illegal
);

  typedef struct packed {
    logic       brinco;
    logic       equal;
    logic       greater_equal;
    logic       less_equal;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       flag_rd_src;
    logic       alu_data;
    logic       enable_read;
    logic       enable_write;
    logic       write_data_src;
    logic       operand_flag;
    logic [2:0] alu_op_s;
    logic [2:0] alu_op_v;
    logic       alu_src;
    logic       reg_write_v;
    logic       reg_write_s;
    logic [1:0] imm_src;
    logic [1:0] reg_src1;
    logic [1:0] reg_dest;
    logic       reg_src2;
  } ctrl_t;

  typedef enum logic [2:0] {ClsNone, ClsArith, ClsMem, ClsStall, ClsIllegal} cls_e;

  localparam int unsigned NumCnt     = 5;
  localparam int unsigned IdxInstr   = 0;
  localparam int unsigned IdxArith   = 1;
  localparam int unsigned IdxMem     = 2;
  localparam int unsigned IdxStall   = 3;
  localparam int unsigned IdxIllegal = 4;

  logic [4:0] op;
  ctrl_t      cw;
  logic       ill;
  cls_e       cls;
  logic       accept;

  logic        out_valid_q;
  logic [28:0] ctrl_word_q;
  logic        illegal_q;

  logic [CNT_W-1:0] cnt_q [NumCnt];
  logic [CNT_W-1:0] cnt_d [NumCnt];
  logic [CNT_W-1:0] snp_q [NumCnt];
  logic [NumCnt-1:0] hit;

  assign op = bus.opcode;

  always_comb begin
    cw  = '0;
    ill = 1'b0;
    cls = ClsNone;
    case (bus.instr_type)
      2'b00: begin
        cls        = ClsMem;
        cw.alu_src = 1'b1;
        cw.imm_src = 2'b11;
        case (op[4:3])
          2'b00: begin
            cw.mem_read    = 1'b1;
            cw.reg_write_s = 1'b1;
            cw.mem_to_reg  = 1'b1;
          end
          2'b01: cw.mem_write = 1'b1;
          2'b10: begin
            cw.mem_read    = 1'b1;
            cw.enable_read = 1'b1;
            cw.reg_write_v = 1'b1;
            cw.mem_to_reg  = 1'b1;
            cw.flag_rd_src = 1'b1;
          end
          default: begin
            cw.enable_write   = 1'b1;
            cw.write_data_src = 1'b1;
          end
        endcase
      end
      2'b01: begin
        if (op[4]) begin
          cls            = ClsArith;
          cw.reg_write_s = 1'b1;
          cw.alu_src     = 1'b1;
          cw.imm_src     = 2'b11;
          cw.reg_src1    = 2'b10;
          cw.reg_dest    = 2'b10;
          cw.alu_op_s    = op[3:1];
        end else begin
          case (op[3:0])
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: begin
              cls            = ClsArith;
              cw.reg_write_s = 1'b1;
              cw.reg_src1    = 2'b01;
              cw.reg_src2    = 1'b1;
              cw.reg_dest    = 2'b01;
              // Op 4 is the odd one out: it selects ALU operation 7.
              cw.alu_op_s    = op[2] ? 3'b111 : op[2:0];
            end
            4'b0101: cls = ClsStall;
            4'b0110: begin
              cls            = ClsStall;
              cw.mem_read    = 1'b1;
              cw.enable_read = 1'b1;
              cw.reg_write_v = 1'b1;
              cw.mem_to_reg  = 1'b1;
              cw.flag_rd_src = 1'b1;
            end
            4'b0111: begin
              cls               = ClsStall;
              cw.mem_write      = 1'b1;
              cw.enable_write   = 1'b1;
              cw.write_data_src = 1'b1;
            end
            default: ill = 1'b1;
          endcase
        end
      end
      2'b10: begin
        cw.alu_op_s = 3'b001;
        cw.imm_src  = 2'b10;
        cw.reg_src1 = 2'b11;
        case (op[4:3])
          2'b00:   cw.brinco        = 1'b1;
          2'b01:   cw.less_equal    = 1'b1;
          2'b10:   cw.equal         = 1'b1;
          default: cw.greater_equal = 1'b1;
        endcase
      end
      default: begin
        cls            = ClsArith;
        cw.alu_data    = 1'b1;
        cw.reg_write_v = 1'b1;
        case (op)
          5'b00000, 5'b00001, 5'b01010, 5'b01011: begin
            cw.alu_op_v     = op[0] ? 3'b010 : 3'b000;
            cw.reg_src1     = 2'b01;
            cw.reg_src2     = 1'b1;
            cw.reg_dest     = 2'b01;
            cw.operand_flag = op[3];
          end
          5'b10000, 5'b10001, 5'b10010, 5'b10011,
          5'b10100, 5'b10101, 5'b11000, 5'b11001: begin
            case (op[4:1])
              4'b1000: cw.alu_op_v = 3'b011;
              4'b1001: cw.alu_op_v = 3'b100;
              4'b1010: cw.alu_op_v = 3'b101;
              default: cw.alu_op_v = 3'b110;
            endcase
            cw.alu_src      = 1'b1;
            cw.operand_flag = 1'b1;
            cw.imm_src      = 2'b11;
            cw.reg_src1     = 2'b10;
            cw.reg_dest     = 2'b10;
          end
          default: ill = 1'b1;
        endcase
      end
    endcase
    if (ill) begin
      cw  = '0;
      cls = ClsIllegal;
    end
  end

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.ctrl_word = ctrl_word_q;
  assign bus.illegal   = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_word_q <= '0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_word_q <= cw;
      illegal_q   <= ill;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (SATURATE && (&v)) return v;
    return v + 1'b1;
  endfunction

  // Clear is applied first so a same-cycle accept lands on a zeroed counter.
  always_comb begin
    hit           = '0;
    hit[IdxInstr] = accept;
    case (cls)
      ClsArith:   hit[IdxArith]   = accept;
      ClsMem:     hit[IdxMem]     = accept;
      ClsStall:   hit[IdxStall]   = accept;
      ClsIllegal: hit[IdxIllegal] = accept;
      default:    ;
    endcase
    for (int i = 0; i < NumCnt; i++) begin
      cnt_d[i] = cnt_clr ? '0 : cnt_q[i];
      if (hit[i]) cnt_d[i] = bump(cnt_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumCnt; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
        snp_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
        if (snap) snp_q[i] <= cnt_q[i];
      end
    end
  end

  assign cnt_instr   = cnt_q[IdxInstr];
  assign cnt_arith   = cnt_q[IdxArith];
  assign cnt_mem     = cnt_q[IdxMem];
  assign cnt_stall   = cnt_q[IdxStall];
  assign cnt_illegal = cnt_q[IdxIllegal];
  assign snp_instr   = snp_q[IdxInstr];
  assign snp_arith   = snp_q[IdxArith];
  assign snp_mem     = snp_q[IdxMem];
  assign snp_stall   = snp_q[IdxStall];
  assign snp_illegal = snp_q[IdxIllegal];

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: scoreboarded control words, modelled
// counters, and two narrow-counter instances for saturate/wrap behaviour.
module tb_ctrl_decode_pipe;
  localparam int W = 19;

  logic clk = 1'b0;
  logic rst, cnt_clr, snap;
  always #5 clk = ~clk;

  ctrl_decode_pipe_if bus ();
  ctrl_decode_pipe_if bus_s ();
  ctrl_decode_pipe_if bus_w ();

  logic [W-1:0] c_instr, c_arith, c_mem, c_stall, c_ill;
  logic [W-1:0] s_instr, s_arith, s_mem, s_stall, s_ill;
  logic [3:0] sc_instr, sc_arith, sc_mem, sc_stall, sc_ill;
  logic [3:0] ss_instr, ss_arith, ss_mem, ss_stall, ss_ill;
  logic [3:0] wc_instr, wc_arith, wc_mem, wc_stall, wc_ill;
  logic [3:0] ws_instr, ws_arith, ws_mem, ws_stall, ws_ill;

  ctrl_decode_pipe #(.CNT_W(W), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .cnt_clr(cnt_clr), .snap(snap),
    .cnt_instr(c_instr), .cnt_arith(c_arith), .cnt_mem(c_mem), .cnt_stall(c_stall),
    .cnt_illegal(c_ill), .snp_instr(s_instr), .snp_arith(s_arith), .snp_mem(s_mem),
    .snp_stall(s_stall), .snp_illegal(s_ill)
  );

  ctrl_decode_pipe #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_s.slave), .cnt_clr(1'b0), .snap(1'b0),
    .cnt_instr(sc_instr), .cnt_arith(sc_arith), .cnt_mem(sc_mem), .cnt_stall(sc_stall),
    .cnt_illegal(sc_ill), .snp_instr(ss_instr), .snp_arith(ss_arith), .snp_mem(ss_mem),
    .snp_stall(ss_stall), .snp_illegal(ss_ill)
  );

  ctrl_decode_pipe #(.CNT_W(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus_w.slave), .cnt_clr(1'b0), .snap(1'b0),
    .cnt_instr(wc_instr), .cnt_arith(wc_arith), .cnt_mem(wc_mem), .cnt_stall(wc_stall),
    .cnt_illegal(wc_ill), .snp_instr(ws_instr), .snp_arith(ws_arith), .snp_mem(ws_mem),
    .snp_stall(ws_stall), .snp_illegal(ws_ill)
  );

  localparam int CInstr = 0, CArith = 1, CMem = 2, CStall = 3, CIll = 4, CNone = 5;

  int checks = 0;
  int errors = 0;
  logic [29:0] sb[$];
  int m_cnt[5];
  int s_cnt[5];
  logic last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: returns {illegal, ctrl_word} and the counter class.
  function automatic logic [29:0] exp_dec(input logic [1:0] t, input logic [4:0] op,
                                          output int cls);
    logic [28:0] w;
    logic ill;
    w = '0; ill = 1'b0; cls = CNone;
    case (t)
      2'b00: begin
        cls = CMem; w[9] = 1; w[6:5] = 2'b11;
        case (op[4:3])
          2'b00: begin w[23] = 1; w[7] = 1; w[24] = 1; end
          2'b01: w[22] = 1;
          2'b10: begin w[23] = 1; w[19] = 1; w[8] = 1; w[24] = 1; w[21] = 1; end
          default: begin w[18] = 1; w[17] = 1; end
        endcase
      end
      2'b01: begin
        if (op[4]) begin
          cls = CArith; w[7] = 1; w[9] = 1; w[6:5] = 2'b11; w[4:3] = 2'b10;
          w[2:1] = 2'b10; w[15:13] = op[3:1];
        end else if (op <= 5'd4) begin
          cls = CArith; w[7] = 1; w[4:3] = 2'b01; w[0] = 1; w[2:1] = 2'b01;
          w[15:13] = (op == 5'd4) ? 3'b111 : op[2:0];
        end else if (op == 5'd5) begin
          cls = CStall;
        end else if (op == 5'd6) begin
          cls = CStall; w[23] = 1; w[19] = 1; w[8] = 1; w[24] = 1; w[21] = 1;
        end else if (op == 5'd7) begin
          cls = CStall; w[22] = 1; w[18] = 1; w[17] = 1;
        end else begin
          ill = 1'b1;
        end
      end
      2'b10: begin
        w[15:13] = 3'b001; w[6:5] = 2'b10; w[4:3] = 2'b11;
        case (op[4:3])
          2'b00: w[28] = 1;
          2'b01: w[25] = 1;
          2'b10: w[27] = 1;
          default: w[26] = 1;
        endcase
      end
      default: begin
        cls = CArith; w[20] = 1; w[8] = 1;
        if (op == 5'd0 || op == 5'd1 || op == 5'd10 || op == 5'd11) begin
          w[12:10] = op[0] ? 3'b010 : 3'b000;
          w[4:3] = 2'b01; w[0] = 1; w[2:1] = 2'b01; w[16] = op[3];
        end else if (op[4:1] == 4'b1000 || op[4:1] == 4'b1001 ||
                     op[4:1] == 4'b1010 || op[4:1] == 4'b1100) begin
          case (op[4:1])
            4'b1000: w[12:10] = 3'b011;
            4'b1001: w[12:10] = 3'b100;
            4'b1010: w[12:10] = 3'b101;
            default: w[12:10] = 3'b110;
          endcase
          w[9] = 1; w[16] = 1; w[6:5] = 2'b11; w[4:3] = 2'b10; w[2:1] = 2'b10;
        end else begin
          ill = 1'b1;
        end
      end
    endcase
    if (ill) begin
      w = '0;
      cls = CIll;
    end
    return {ill, w};
  endfunction

  // Observe at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    logic [29:0] e;
    int cls;
    @(negedge clk);
    last_acc = 1'b0;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 5; i++) begin m_cnt[i] = 0; s_cnt[i] = 0; end
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ctrl_word", {3'b0, bus.ctrl_word}, {3'b0, e[28:0]});
          chk("illegal", {31'b0, bus.illegal}, {31'b0, e[29]});
        end
      end
      last_acc = bus.in_valid && bus.in_ready;
      e = exp_dec(bus.instr_type, bus.opcode, cls);
      if (last_acc) sb.push_back(e);
      if (snap) for (int i = 0; i < 5; i++) s_cnt[i] = m_cnt[i];
      if (cnt_clr) for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      if (last_acc) begin
        m_cnt[CInstr]++;
        if (cls != CNone) m_cnt[cls]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_instr"}, 32'(c_instr), 32'(m_cnt[CInstr]));
    chk({tag, "_arith"}, 32'(c_arith), 32'(m_cnt[CArith]));
    chk({tag, "_mem"}, 32'(c_mem), 32'(m_cnt[CMem]));
    chk({tag, "_stall"}, 32'(c_stall), 32'(m_cnt[CStall]));
    chk({tag, "_illegal"}, 32'(c_ill), 32'(m_cnt[CIll]));
  endtask

  task automatic send(input logic [1:0] t, input logic [4:0] op);
    bus.in_valid = 1'b1; bus.instr_type = t; bus.opcode = op; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; cnt_clr = 1'b0; snap = 1'b0;
    bus.in_valid = 1'b0; bus.instr_type = 2'b00; bus.opcode = '0; bus.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.instr_type = 2'b00; bus_s.opcode = '0; bus_s.out_ready = 1'b1;
    bus_w.in_valid = 1'b0; bus_w.instr_type = 2'b00; bus_w.opcode = '0; bus_w.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_ctrl_word", {3'b0, bus.ctrl_word}, 32'd0);
    chk("rst_illegal", {31'b0, bus.illegal}, 32'd0);
    chk("rst_snp_instr", 32'(s_instr), 32'd0);
    chk_counters("rst");

    // First transaction: one-cycle latency.
    send(2'b01, 5'b00000);
    chk("first_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("first_word", {3'b0, bus.ctrl_word}, 32'h0000_008B);
    chk("first_cnt_instr", 32'(c_instr), 32'd1);
    chk("first_cnt_arith", 32'(c_arith), 32'd1);
    tick();

    // Backpressure: A held, B waits, both delivered once, in order.
    bus.in_valid = 1'b1; bus.instr_type = 2'b01; bus.opcode = 5'b00001; bus.out_ready = 1'b0;
    tick();
    bus.instr_type = 2'b00; bus.opcode = 5'b01000;
    #1;
    chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_hold_word", {3'b0, bus.ctrl_word}, {3'b0, sb[0][28:0]});
    tick();
    bus.out_ready = 1'b1;
    tick();
    chk("bp_b_accepted", {31'b0, last_acc}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drained", sb.size(), 32'd0);
    chk_counters("bp");

    // Every type/opcode under random backpressure and bubbles.
    for (int k = 0; k < 128; k++) begin
      bus.instr_type = k[6:5]; bus.opcode = k[4:0]; bus.in_valid = 1'b1;
      n = 0;
      do begin
        bus.out_ready = ($urandom_range(3) != 0);
        tick();
        n++;
      end while (!last_acc && n < 50);
      if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
      if ($urandom_range(3) == 0) begin bus.in_valid = 1'b0; tick(); end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    tick();
    chk("sweep_drained", sb.size(), 32'd0);
    chk_counters("sweep");
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("sweep_snp_instr", 32'(s_instr), 32'(s_cnt[CInstr]));
    chk("sweep_snp_arith", 32'(s_arith), 32'(s_cnt[CArith]));
    chk("sweep_snp_mem", 32'(s_mem), 32'(s_cnt[CMem]));

    // Illegal encodings.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    send(2'b01, 5'b01000);
    chk("ill1_flag", {31'b0, bus.illegal}, 32'd1);
    chk("ill1_word", {3'b0, bus.ctrl_word}, 32'd0);
    send(2'b11, 5'b11110);
    chk("ill2_flag", {31'b0, bus.illegal}, 32'd1);
    tick();
    chk("ill_cnt_illegal", 32'(c_ill), 32'd2);
    chk("ill_cnt_instr", 32'(c_instr), 32'd2);

    // Clear + snapshot + accept in one cycle.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 7; i++) send(2'b01, 5'b00101);
    chk("pre_cnt_stall", 32'(c_stall), 32'd7);
    cnt_clr = 1'b1; snap = 1'b1;
    send(2'b01, 5'b00101);
    cnt_clr = 1'b0; snap = 1'b0;
    chk("cs_snp_stall", 32'(s_stall), 32'd7);
    chk("cs_cnt_stall", 32'(c_stall), 32'd1);
    chk("cs_cnt_instr", 32'(c_instr), 32'd1);
    chk("cs_snp_instr", 32'(s_instr), 32'd7);
    tick();
    chk_counters("cs");

    // Narrow counters: saturate vs wrap.
    bus_s.in_valid = 1'b1; bus_w.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus_s.in_valid = 1'b0; bus_w.in_valid = 1'b0;
    tick();
    chk("sat_cnt_mem", 32'(sc_mem), 32'd15);
    chk("sat_cnt_instr", 32'(sc_instr), 32'd15);
    chk("wrap_cnt_mem", 32'(wc_mem), 32'd4);
    chk("wrap_cnt_instr", 32'(wc_instr), 32'd4);

    // Reset while a word is stalled at the output.
    bus.in_valid = 1'b1; bus.instr_type = 2'b00; bus.opcode = 5'b10000; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mid_valid_held", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_word", {3'b0, bus.ctrl_word}, 32'd0);
    chk("mid_rst_snp_stall", 32'(s_stall), 32'd0);
    chk_counters("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
